decode_stage_pipe: RTL
======================

// Module: decode_stage_pipe
// PURPOSE
//  Parametrised decode stage with built-in ID/EX pipeline register. Splits the
//  instruction into opcode/rs/rt/rd/imm, reads a 2R1W register file with
//  write-back bypass, sign-extends the immediate and registers all results.
//  Adds a valid/ready handshake, load-use stall detection and a flush.
//  Sits between the fetch stage (IF/ID) and the execute stage.
// PARAMETERS
//  XLEN     16  data/instruction width in bits
//  OPC_W    3   opcode width, field instr[XLEN-1 -: OPC_W]
//  REG_AW   3   register index width; register file depth = 2**REG_AW
//  IMM_W    7   immediate width, field instr[IMM_W-1:0]
//  LW_OPC   3'b100  opcode of the load instruction (destination = rt)
//  R0_ZERO  1   1: register 0 reads 0 and ignores writes
// PORTS
//  clk          in   1       clock, rising edge
//  rst_n        in   1       asynchronous reset, active low
//  in_valid     in   1       instr holds a valid instruction
//  in_ready     out  1       stage accepts instr this cycle
//  instr        in   XLEN    instruction from IF/ID
//  flush        in   1       kill the ID/EX entry and the accepted instruction
//  wb_we        in   1       register file write enable
//  wb_addr      in   REG_AW  write register index
//  wb_data      in   XLEN    write data
//  out_valid    out  1       ID/EX entry valid
//  out_ready    in   1       execute stage consumes the entry
//  out_opcode   out  OPC_W   registered opcode
//  out_rs/rt/rd out  REG_AW  registered register indices
//  out_rd1/rd2  out  XLEN    registered read data for rs/rt
//  out_imm      out  XLEN    registered sign-extended immediate
// BEHAVIOUR
//  - Fields: rs = instr[XLEN-OPC_W-1 -: REG_AW]; rt = the next REG_AW bits; rd = the next REG_AW
//    bits; imm = instr[IMM_W-1:0], sign-extended from bit IMM_W-1 to XLEN.
//  - Reset (rst_n=0, async): out_valid=0; all out_* fields=0; all registers=0.
//  - Register file: write on rising clk when wb_we (and wb_addr!=0 if R0_ZERO).
//    Combinational read. Bypass: if wb_we and wb_addr equals a read index, the
//    read returns wb_data in the same cycle. With R0_ZERO, index 0 always reads 0.
//  - Latency: an instruction accepted in cycle N appears on out_* in cycle N+1.
//  - advance = !out_valid | out_ready. hazard = out_valid & out_opcode==LW_OPC &
//    (out_rt==rs | out_rt==rt) & in_valid. No hazard on index 0 when R0_ZERO.
//  - in_ready = advance & !hazard & !flush.
//  - On advance: if in_valid&in_ready, load the entry and set out_valid=1;
//    otherwise set out_valid=0 (bubble; the hazard inserts exactly one bubble).
//  - No advance: all out_* hold their values, bit-stable.
//  - flush (synchronous): next out_valid=0; in_ready=0, so instr is dropped.
//    Register-file writes still occur. Flush overrides stall and handshake.
//  - Register-file writes are never blocked by stalls or bubbles.
//  - Reset mid-transfer: the entry is lost; out_valid=0 on the next cycle.
// STRUCTURE
//  - Package decode_pkg: field-offset localparams, LW_OPC default, and a decoded-
//    instruction struct {opcode, rs, rt, rd, imm}.
//  - Sub-module regfile_bypass (2R1W, REG_AW/XLEN/R0_ZERO) holds the storage and
//    bypass mux. The top level holds field extraction, hazard logic and the ID/EX register.
// TESTING
//  1 Reset: rst_n=0 with clk running -> out_valid=0, out_rd1=0, in_ready=1 after release.
//  2 Write r3=16'h1234, then decode instr 16'h0D80 (rs=3, rt=3) -> next cycle
//    out_rd1=out_rd2=16'h1234, out_valid=1.
//  3 Bypass: wb_we=1, wb_addr=5, wb_data=16'hBEEF in the same cycle instr reads rs=5
//    -> out_rd1=16'hBEEF.
//  4 Imm: instr[6:0]=7'h40 -> out_imm=16'hFFC0; 7'h3F -> out_imm=16'h003F.
//  5 Load-use: lw with rt=2 in ID/EX, next instr with rs=2 -> in_ready=0 for one
//    cycle, one bubble (out_valid=0), then accepted; out_ready=0 holds all out_* stable.
//  6 Flush with out_valid=1 and in_valid=1 -> out_valid=0 next cycle, instr not
//    captured, a concurrent wb write still lands.

Source files
------------

// File: rtl/decode_stage_pipe_pkg.sv
// rtl/decode_stage_pipe_pkg.sv - decode stage field layout, defaults and decoded-instruction type
package decode_pkg;

    localparam int XLEN_DEF   = 16;
    localparam int OPC_W_DEF  = 3;
    localparam int REG_AW_DEF = 3;
    localparam int IMM_W_DEF  = 7;
    localparam logic [OPC_W_DEF-1:0] LW_OPC_DEF = 3'b100;

    localparam int RS_MSB = XLEN_DEF - OPC_W_DEF - 1;
    localparam int RT_MSB = RS_MSB - REG_AW_DEF;
    localparam int RD_MSB = RT_MSB - REG_AW_DEF;

    typedef struct packed {
        logic [OPC_W_DEF-1:0]  opcode;
        logic [REG_AW_DEF-1:0] rs;
        logic [REG_AW_DEF-1:0] rt;
        logic [REG_AW_DEF-1:0] rd;
        logic [XLEN_DEF-1:0]   imm;
    } decoded_t;

    function automatic decoded_t decode_instr(input logic [XLEN_DEF-1:0] instr);
        decoded_t d;
        d.opcode = instr[XLEN_DEF-1 -: OPC_W_DEF];
        d.rs     = instr[RS_MSB -: REG_AW_DEF];
        d.rt     = instr[RT_MSB -: REG_AW_DEF];
        d.rd     = instr[RD_MSB -: REG_AW_DEF];
        d.imm    = {{(XLEN_DEF-IMM_W_DEF){instr[IMM_W_DEF-1]}}, instr[IMM_W_DEF-1:0]};
        return d;
    endfunction

endpackage

// File: rtl/decode_stage_pipe_if.sv
// rtl/decode_stage_pipe_if.sv - fetch/execute handshake, write-back and ID/EX output bundle
interface decode_stage_pipe_if #(
    parameter int XLEN   = 16,
    parameter int OPC_W  = 3,
    parameter int REG_AW = 3
);
    logic              in_valid;
    logic              in_ready;
    logic [XLEN-1:0]   instr;
    logic              flush;
    logic              wb_we;
    logic [REG_AW-1:0] wb_addr;
    logic [XLEN-1:0]   wb_data;
    logic              out_valid;
    logic              out_ready;
    logic [OPC_W-1:0]  out_opcode;
    logic [REG_AW-1:0] out_rs;
    logic [REG_AW-1:0] out_rt;
    logic [REG_AW-1:0] out_rd;
    logic [XLEN-1:0]   out_rd1;
    logic [XLEN-1:0]   out_rd2;
    logic [XLEN-1:0]   out_imm;

    modport master (
        output in_valid, instr, flush, wb_we, wb_addr, wb_data, out_ready,
        input  in_ready, out_valid, out_opcode, out_rs, out_rt, out_rd,
               out_rd1, out_rd2, out_imm
    );

    modport slave (
        input  in_valid, instr, flush, wb_we, wb_addr, wb_data, out_ready,
        output in_ready, out_valid, out_opcode, out_rs, out_rt, out_rd,
               out_rd1, out_rd2, out_imm
    );
endinterface

// File: rtl/decode_stage_pipe_regfile.sv
// rtl/decode_stage_pipe_regfile.sv - 2R1W register file with same-cycle write-back bypass
module regfile_bypass #(
    parameter int REG_AW  = 3,
    parameter int XLEN    = 16,
    parameter bit R0_ZERO = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [XLEN-1:0]   wdata,
    input  logic [REG_AW-1:0] raddr1,
    input  logic [REG_AW-1:0] raddr2,
    output logic [XLEN-1:0]   rdata1,
    output logic [XLEN-1:0]   rdata2
);
    localparam int DEPTH = 2 ** REG_AW;

    logic [XLEN-1:0] mem [DEPTH];
    logic            wr_en;

    assign wr_en = we && !(R0_ZERO && (waddr == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[waddr] <= wdata;
        end
    end

    // Zero register wins over the bypass so a write to r0 never leaks through.
    always_comb begin
        rdata1 = mem[raddr1];
        if (R0_ZERO && (raddr1 == '0)) begin
            rdata1 = '0;
        end else if (we && (waddr == raddr1)) begin
            rdata1 = wdata;
        end
    end

    always_comb begin
        rdata2 = mem[raddr2];
        if (R0_ZERO && (raddr2 == '0)) begin
            rdata2 = '0;
        end else if (we && (waddr == raddr2)) begin
            rdata2 = wdata;
        end
    end
endmodule

// File: rtl/decode_stage_pipe.sv
// rtl/decode_stage_pipe.sv - decode stage: field split, register read, load-use stall, ID/EX register
module decode_stage_pipe
    import decode_pkg::*;
#(
    parameter int               XLEN    = XLEN_DEF,
    parameter int               OPC_W   = OPC_W_DEF,
    parameter int               REG_AW  = REG_AW_DEF,
    parameter int               IMM_W   = IMM_W_DEF,
    parameter logic [OPC_W-1:0] LW_OPC  = LW_OPC_DEF,
    parameter bit               R0_ZERO = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    decode_stage_pipe_if.slave  bus
);
    localparam int RS_HI = XLEN - OPC_W - 1;
    localparam int RT_HI = RS_HI - REG_AW;
    localparam int RD_HI = RT_HI - REG_AW;

    logic [OPC_W-1:0]  opcode;
    logic [REG_AW-1:0] rs, rt, rd;
    logic [XLEN-1:0]   imm_ext;
    logic [XLEN-1:0]   rd1, rd2;

    logic              q_valid;
    logic [OPC_W-1:0]  q_opcode;
    logic [REG_AW-1:0] q_rs, q_rt, q_rd;
    logic [XLEN-1:0]   q_rd1, q_rd2, q_imm;

    logic advance, hazard, rs_hit, rt_hit, ready, accept;

    assign opcode  = bus.instr[XLEN-1 -: OPC_W];
    assign rs      = bus.instr[RS_HI -: REG_AW];
    assign rt      = bus.instr[RT_HI -: REG_AW];
    assign rd      = bus.instr[RD_HI -: REG_AW];
    assign imm_ext = {{(XLEN-IMM_W){bus.instr[IMM_W-1]}}, bus.instr[IMM_W-1:0]};

    regfile_bypass #(
        .REG_AW  (REG_AW),
        .XLEN    (XLEN),
        .R0_ZERO (R0_ZERO)
    ) u_regfile (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (bus.wb_we),
        .waddr  (bus.wb_addr),
        .wdata  (bus.wb_data),
        .raddr1 (rs),
        .raddr2 (rt),
        .rdata1 (rd1),
        .rdata2 (rd2)
    );

    // A load in ID/EX whose result the incoming instruction reads must wait one slot.
    assign rs_hit  = (q_rt == rs) && !(R0_ZERO && (rs == '0));
    assign rt_hit  = (q_rt == rt) && !(R0_ZERO && (rt == '0));
    assign hazard  = q_valid && (q_opcode == LW_OPC) && (rs_hit || rt_hit) && bus.in_valid;
    assign advance = !q_valid || bus.out_ready;
    assign ready   = advance && !hazard && !bus.flush;
    assign accept  = bus.in_valid && ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_valid  <= 1'b0;
            q_opcode <= '0;
            q_rs     <= '0;
            q_rt     <= '0;
            q_rd     <= '0;
            q_rd1    <= '0;
            q_rd2    <= '0;
            q_imm    <= '0;
        end else if (bus.flush) begin
            q_valid <= 1'b0;
        end else if (advance) begin
            q_valid <= accept;
            if (accept) begin
                q_opcode <= opcode;
                q_rs     <= rs;
                q_rt     <= rt;
                q_rd     <= rd;
                q_rd1    <= rd1;
                q_rd2    <= rd2;
                q_imm    <= imm_ext;
            end
        end
    end

    assign bus.in_ready   = ready;
    assign bus.out_valid  = q_valid;
    assign bus.out_opcode = q_opcode;
    assign bus.out_rs     = q_rs;
    assign bus.out_rt     = q_rt;
    assign bus.out_rd     = q_rd;
    assign bus.out_rd1    = q_rd1;
    assign bus.out_rd2    = q_rd2;
    assign bus.out_imm    = q_imm;
endmodule
